// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor, start/done handshake.
// Optional macro FPADD_RNE_EN selects round-to-nearest-even instead of truncation.
module fp_add_seq #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        inv
);
    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0] a_r, b_r;
    logic        sub_r;
    logic        spec_r, spec_inv_r;
    logic [31:0] spec_res_r;
    logic        sign_l_r, sign_s_r;
    logic [7:0]  exp_l_r, diff_r;
    logic [26:0] man_l_r, man_s_r;
    logic [27:0] sum_r;
    logic        sign_r;
    logic        n_zero_r, n_sign_r;
    logic signed [9:0] n_exp_r;
    logic [26:0] n_man_r;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = UNPACK;
            UNPACK:  state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Unpack, special-case detection and magnitude ordering
    logic [7:0]  ea, eb;
    logic        sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, swap;
    logic        u_spec, u_inv;
    logic [31:0] u_res;

    always_comb begin
        ea    = a_r[30:23];
        eb    = b_r[30:23];
        sa    = a_r[31];
        sb    = b_r[31] ^ sub_r;
        za    = (ea == 8'd0);
        zb    = (eb == 8'd0);
        nan_a = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
        nan_b = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
        inf_a = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
        inf_b = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
        swap  = (b_r[30:0] > a_r[30:0]);
        u_spec = 1'b1;
        u_inv  = 1'b0;
        u_res  = 32'd0;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            u_res = CANON_NAN;
            u_inv = 1'b1;
        end else if (inf_a) begin
            u_res = a_r;
        end else if (inf_b) begin
            u_res = {sb, b_r[30:0]};
        end else if (za && zb) begin
            u_res = {sa & sb, 31'd0};
        end else if (za) begin
            u_res = {sb, b_r[30:0]};
        end else if (zb) begin
            u_res = a_r;
        end else begin
            u_spec = 1'b0;
        end
    end

    // Align: shift smaller mantissa, collapse lost bits into sticky
    logic [26:0] ones, mask, shifted, al;
    always_comb begin
        ones    = '1;
        mask    = ~(ones << diff_r);
        shifted = man_s_r >> diff_r;
        if (diff_r >= 8'd27)
            al = {26'd0, |man_s_r};
        else
            al = {shifted[26:1], shifted[0] | (|(man_s_r & mask))};
    end

    // Normalize
    logic [4:0]        lz;
    logic signed [9:0] ne;
    logic [26:0]       nm;
    logic              nzero, nsign;
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum_r[i]) lz = 5'(26 - i);
        if (sum_r[27]) begin
            nm = {sum_r[27:2], sum_r[1] | sum_r[0]};
            ne = $signed({2'b00, exp_l_r}) + 10'sd1;
        end else begin
            nm = sum_r[26:0] << lz;
            ne = $signed({2'b00, exp_l_r}) - $signed({5'd0, lz});
        end
        nzero = 1'b0;
        nsign = sign_r;
        if (sum_r == 28'd0) begin
            nzero = 1'b1;
            nsign = 1'b0;
        end else if (ne <= 10'sd0) begin
            nzero = 1'b1;
        end
    end

    // Round
    logic        inc, r_ovf;
    logic [24:0] rm;
    logic [22:0] rf;
    logic signed [9:0] re;
    logic [31:0] r_res;
    always_comb begin
`ifdef FPADD_RNE_EN
        inc = n_man_r[2] & (n_man_r[1] | n_man_r[0] | n_man_r[3]);
`else
        inc = 1'b0;
`endif
        rm = {1'b0, n_man_r[26:3]} + {24'd0, inc};
        if (rm[24]) begin
            rf = rm[23:1];
            re = n_exp_r + 10'sd1;
        end else begin
            rf = rm[22:0];
            re = n_exp_r;
        end
        r_ovf = 1'b0;
        if (n_zero_r) begin
            r_res = {n_sign_r, 31'd0};
        end else if (re >= 10'sd255) begin
            r_res = {n_sign_r, 8'hFF, 23'd0};
            r_ovf = 1'b1;
        end else begin
            r_res = {n_sign_r, re[7:0], rf};
        end
    end

    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: if (start) begin
                a_r   <= a;
                b_r   <= b;
                sub_r <= sub;
            end
            UNPACK: begin
                spec_r     <= u_spec;
                spec_inv_r <= u_inv;
                spec_res_r <= u_res;
                sign_l_r   <= swap ? sb : sa;
                sign_s_r   <= swap ? sa : sb;
                exp_l_r    <= swap ? eb : ea;
                diff_r     <= swap ? (eb - ea) : (ea - eb);
                man_l_r    <= swap ? {1'b1, b_r[22:0], 3'b000}
                                   : {1'b1, a_r[22:0], 3'b000};
                man_s_r    <= swap ? {1'b1, a_r[22:0], 3'b000}
                                   : {1'b1, b_r[22:0], 3'b000};
            end
            ALIGN: man_s_r <= al;
            ADD: begin
                sign_r <= sign_l_r;
                if (sign_l_r == sign_s_r)
                    sum_r <= {1'b0, man_l_r} + {1'b0, man_s_r};
                else
                    sum_r <= {1'b0, man_l_r} - {1'b0, man_s_r};
            end
            NORM: begin
                n_man_r  <= nm;
                n_exp_r  <= ne;
                n_zero_r <= nzero;
                n_sign_r <= nsign;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= 32'd0;
            ovf    <= 1'b0;
            inv    <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
            inv <= 1'b0;
        end else if (state == ROUND) begin
            result <= spec_r ? spec_res_r : r_res;
            ovf    <= spec_r ? 1'b0 : r_ovf;
            inv    <= spec_r ? spec_inv_r : 1'b0;
        end
    end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder/subtractor.
- Sits directly downstream of the integer-to-IEEE-754 converter and consumes its packed 32-bit floats as operands.
- Used by the datapath's floating-point extension.
- Fixed-latency start/done handshake, one operation in flight.

Parameters:
- CANON_NAN, 32'h7FC00000, value driven on result for any invalid operation.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  32  operand A (IEEE-754 single).
- b  in  32  operand B (IEEE-754 single).
- sub  in  1  0: a+b, 1: a-b; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  packed IEEE-754 sum; held until the next accepted start.
- ovf  out  1  overflow flag, valid with done, held with result.
- inv  out  1  invalid-operation flag, valid with done, held with result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values: state=IDLE, busy=0, done=0, result=0, ovf=0, inv=0. Reset mid-operation aborts the operation, with no done pulse.
- FSM and timing:
  - States in order: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
  - Each non-IDLE state lasts exactly 1 cycle.
  - Edge 1 is the edge that samples start=1 in IDLE. done is high for the cycle after edge 6 (state DONE). DONE -> IDLE is unconditional.
  - Throughput: 1 op per 7 cycles.
  - start outside IDLE (including DONE) is ignored. a, b and sub are latched at edge 1 and may change afterwards.
- UNPACK:
  - Effective sign of b = b[31]^sub.
  - An exponent of 0 is treated as signed zero: denormals flush to zero.
  - Mantissa is {1, frac}, 24 bits, extended with 3 bits (guard, round, sticky) to 27 bits.
  - Operands are swapped so the larger {exp, frac} magnitude is the first.
- Special cases are decided in UNPACK and carried as a bypass. Latency stays constant.
  - Any NaN, or inf + (-inf) effective: result=CANON_NAN, inv=1.
  - Otherwise, any inf: result=that inf, signed.
  - Both zero: result=+0, except -0 + -0 effective, which gives -0.
  - One zero: result=the other operand, exactly.
- ALIGN:
  - Shift the smaller mantissa right by the exponent difference; OR all shifted-out bits into sticky.
  - Difference >= 27: the smaller mantissa becomes sticky only.
- ADD: effective add when the signs match, giving a 28-bit sum; otherwise larger minus smaller. Result sign = sign of the larger operand.
- NORM:
  - Exact zero: result +0.
  - Carry out: shift right 1 (sticky accumulates), exp+1.
  - Otherwise: shift left by the leading-zero count, exp -= count.
  - exp <= 0: signed zero.
- ROUND:
  - Default: truncate, dropping G/R/S.
  - Mantissa carry out after rounding: exp+1.
  - exp >= 255: result=signed inf, ovf=1.
- Output is never denormal.
- ovf and inv are cleared at each accepted start.

Optional Feature:
- Macro: FPADD_RNE_EN.
- Defined: ROUND uses round-to-nearest-even. Increment the mantissa iff G & (R | S | LSB).
- Undefined: truncation (round toward zero). No other behaviour differs.

Test Plan:
- a=0x3F800000, b=0x40000000, sub=0, start 1 cycle -> busy high for 6 cycles, done high after edge 6, result=0x40400000, ovf=0, inv=0.
- a=0x3F800000, b=0x3F800000, sub=1 -> result=0x00000000. a=0x80000000, b=0x00000000, sub=1 -> result=0x80000000.
- a=b=0x7F7FFFFF, sub=0 -> result=0x7F800000, ovf=1.
- a=0x7F800000, b=0x7F800000, sub=1 -> result=0x7FC00000, inv=1, done still after edge 6.
- a=0x3F800000, b=0x34400000, sub=0 -> result=0x3F800001 without FPADD_RNE_EN; result=0x3F800002 with it.
- start pulsed on the 3rd busy cycle -> ignored, exactly one done. Reset asserted in ALIGN -> next cycle busy=0, done=0, result=0, and no done follows.
